// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are word indices on uart_addr[3:2].
package uart_tx_pkg;

    localparam logic [31:0] uart_base_addr = 32'h1000_0000;
    localparam logic [31:0] uart_top_addr  = 32'h1000_0010;

    localparam logic [1:0] uart_txdata  = 2'd0;
    localparam logic [1:0] uart_status  = 2'd1;
    localparam logic [1:0] uart_divisor = 2'd2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with occupancy count. A push while full
// and a pop while empty are both ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus responder, divisor register,
// TX FIFO and serialising FSM with a registered txd output.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter logic [15:0] BAUD_RESET = 16'd867
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_txd,
    output logic        uart_irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    uart_state_t state_q, state_d;
    logic [15:0] divisor_q, divisor_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        irq_q, irq_d;
    logic        ovf_q, ovf_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;

    logic          fifo_full, fifo_empty, push, pop, in_win, is_write, busy, bit_end;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [1:0]    word;
    logic [31:0]   status;
    logic          unused_bits;

    assign unused_bits = ^{uart_instr, uart_addr[1:0], uart_wdata[31:16]};

    assign in_win   = (uart_addr < (uart_top_addr - uart_base_addr));
    assign word     = uart_addr[3:2];
    assign is_write = |uart_wstrb;
    assign push     = uart_valid && in_win && (word == uart_txdata) && uart_wstrb[0];
    assign pop      = (state_q == IDLE) && !fifo_empty;
    assign busy     = (state_q != IDLE);
    assign bit_end  = (cnt_q == 16'd0);
    assign status   = {16'h0, 8'(fifo_count), 4'h0, ovf_q, busy, fifo_empty, fifo_full};

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (uart_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        ready_d   = uart_valid;
        rdata_d   = 32'h0;
        divisor_d = divisor_q;
        ovf_d     = ovf_q;
        if (uart_valid && in_win && !is_write) begin
            case (word)
                uart_status:  rdata_d = status;
                uart_divisor: rdata_d = {16'h0, divisor_q};
                default:      rdata_d = 32'h0;
            endcase
        end
        if (uart_valid && in_win && word == uart_divisor) begin
            if (uart_wstrb[0]) divisor_d[7:0]  = uart_wdata[7:0];
            if (uart_wstrb[1]) divisor_d[15:8] = uart_wdata[15:8];
        end
        if (push && fifo_full) begin
            ovf_d = 1'b1;
        end else if (uart_valid && in_win && word == uart_status && uart_wstrb[0] && uart_wdata[3]) begin
            ovf_d = 1'b0;
        end
    end

    // txd_d is the line level for the state being entered, so txd stays glitch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        irq_d   = fifo_empty && !busy;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (pop) begin
                    shift_d = fifo_rdata;
                    cnt_d   = divisor_q;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = divisor_q;
                    idx_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = divisor_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            divisor_q <= BAUD_RESET;
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b1;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q <= shift_d;
    end

    assign uart_txd   = txd_q;
    assign uart_irq   = irq_q;
    assign uart_ready = ready_q;
    assign uart_rdata = rdata_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: bus transactions plus a per-clock log of uart_txd
// compared against frames built from the 8N1 framing rules.
module tb_uart_tx;

    localparam int LOGN = 16384;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic        uart_instr = 1'b0;
    logic [31:0] uart_addr = 32'h0;
    logic [31:0] uart_wdata = 32'h0;
    logic [3:0]  uart_wstrb = 4'h0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_txd;
    logic        uart_irq;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic txlog [LOGN];
    logic [7:0] exp_q [$];

    uart_tx #(.DEPTH(16), .BAUD_RESET(16'd867)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_txd   (uart_txd),
        .uart_irq   (uart_irq)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cyc < LOGN) txlog[cyc] = uart_txd;
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata);
        uart_valid = 1'b1;
        uart_addr  = addr;
        uart_wdata = wdata;
        uart_wstrb = wstrb;
        @(posedge clock); #1;
        uart_valid = 1'b0;
        uart_wstrb = 4'h0;
        check("ready", {31'h0, uart_ready}, 32'h1);
        rdata = uart_rdata;
        @(negedge clock);
    endtask

    task automatic wait_log(input int n);
        while (cyc < n) @(posedge clock);
    endtask

    // Expected line: start (ps clocks), 8 data bits LSB first and stop (pd
    // clocks each), then one idle clock before any following frame.
    task automatic expect_frames(input string tag, input int from, input int ps,
                                 input int pd, input int n);
        int t, errs, p;
        logic b;
        t = from;
        wait_log(t + 1);
        while (txlog[t] !== 1'b0 && t < from + 60) begin
            t++;
            wait_log(t + 1);
        end
        if (txlog[t] !== 1'b0) begin
            check({tag, "_start_seen"}, 32'h0, 32'h1);
            return;
        end
        for (int f = 0; f < n; f++) begin
            errs = 0;
            for (int s = 0; s < 10; s++) begin
                p = (f == 0 && s == 0) ? ps : pd;
                b = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : exp_q[f][s-1];
                for (int k = 0; k < p; k++) begin
                    wait_log(t + 1);
                    if (txlog[t] !== b) errs++;
                    t++;
                end
            end
            wait_log(t + 1);
            if (txlog[t] !== 1'b1) errs++;
            t++;
            check($sformatf("%s_frame%0d_bad_clocks", tag, f), errs, 0);
        end
    endtask

    initial begin
        logic [31:0] r;
        int t0, n, dv, cnt, lows;
        logic [31:0] exp_status;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_txd", {31'h0, uart_txd}, 32'h1);
        check("rst_irq", {31'h0, uart_irq}, 32'h1);
        check("rst_ready", {31'h0, uart_ready}, 32'h0);
        check("rst_rdata", uart_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        bus(32'h4, 32'h0, 4'h0, r);
        check("status_after_reset", r, 32'h0000_0002);
        @(posedge clock); #1;
        check("ready_pulse_ends", {31'h0, uart_ready}, 32'h0);
        check("rdata_idle_zero", uart_rdata, 32'h0);
        @(negedge clock);
        bus(32'hC, 32'h0, 4'h0, r);
        check("reserved_read", r, 32'h0);
        bus(32'h0, 32'h0, 4'h0, r);
        check("txdata_read", r, 32'h0);
        bus(32'h8, 32'h0, 4'h0, r);
        check("divisor_reset", r, 32'd867);
        bus(32'h8, 32'h0000_1234, 4'h3, r);
        bus(32'h8, 32'h0000_FF77, 4'h1, r);
        bus(32'h8, 32'h0, 4'h0, r);
        check("divisor_bytestrobe", r, 32'h0000_1277);

        // Single frame, divisor 3
        bus(32'h8, 32'd3, 4'h3, r);
        exp_q = {};
        exp_q.push_back(8'hA5);
        t0 = cyc;
        bus(32'h0, 32'hA5, 4'h1, r);
        repeat (5) @(negedge clock);
        check("irq_busy", {31'h0, uart_irq}, 32'h0);
        expect_frames("a5", t0, 4, 4, 1);
        repeat (3) @(negedge clock);
        check("irq_done", {31'h0, uart_irq}, 32'h1);

        // Back-to-back, divisor 0
        bus(32'h8, 32'd0, 4'h3, r);
        exp_q = {};
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        t0 = cyc;
        bus(32'h0, 32'h55, 4'h1, r);
        bus(32'h0, 32'h0F, 4'h1, r);
        expect_frames("b2b", t0, 1, 1, 2);
        repeat (3) @(negedge clock);

        // Divisor change during the start bit
        bus(32'h8, 32'd3, 4'h3, r);
        exp_q = {};
        exp_q.push_back(8'($urandom));
        t0 = cyc;
        bus(32'h0, {24'h0, exp_q[0]}, 4'h1, r);
        @(negedge clock);
        bus(32'h8, 32'd9, 4'h3, r);
        expect_frames("divchg", t0, 4, 10, 1);
        repeat (3) @(negedge clock);

        // Randomised bursts
        for (int it = 0; it < 4; it++) begin
            n  = $urandom_range(1, 5);
            dv = $urandom_range(0, 5);
            bus(32'h8, dv, 4'h3, r);
            exp_q = {};
            for (int i = 0; i < n; i++) exp_q.push_back(8'($urandom));
            t0 = cyc;
            for (int i = 0; i < n; i++) bus(32'h0, {24'h0, exp_q[i]}, 4'h1, r);
            // The transmitter takes the first byte the cycle after it lands.
            cnt = (n == 1) ? 1 : n - 1;
            exp_status = (cnt << 8) | ((n > 1) ? 32'h4 : 32'h0);
            bus(32'h4, 32'h0, 4'h0, r);
            check($sformatf("rand%0d_status", it), r, exp_status);
            expect_frames($sformatf("rand%0d", it), t0, dv + 1, dv + 1, n);
            repeat (3) @(negedge clock);
        end

        // Overflow: valid held for 18 writes with a slow divisor
        bus(32'h8, 32'd100, 4'h3, r);
        uart_valid = 1'b1;
        uart_addr  = 32'h0;
        uart_wdata = 32'h0;
        uart_wstrb = 4'h1;
        for (int i = 0; i < 18; i++) begin
            @(posedge clock); #1;
            check($sformatf("held_ready%0d", i), {31'h0, uart_ready}, 32'h1);
            if (i == 17) begin
                uart_valid = 1'b0;
                uart_wstrb = 4'h0;
            end
        end
        @(posedge clock); #1;
        check("held_ready_drop", {31'h0, uart_ready}, 32'h0);
        @(negedge clock);
        bus(32'h4, 32'h0, 4'h0, r);
        check("status_overflow", r, 32'h0000_100D);
        bus(32'h4, 32'h8, 4'h1, r);
        bus(32'h4, 32'h0, 4'h0, r);
        check("status_ovf_cleared", r, 32'h0000_1005);

        // Reset in the middle of the data bits of a 0x00 byte
        repeat (150) @(negedge clock);
        check("mid_data_txd_low", {31'h0, uart_txd}, 32'h0);
        reset = 1'b1;
        #1;
        check("async_rst_txd", {31'h0, uart_txd}, 32'h1);
        check("async_rst_ready", {31'h0, uart_ready}, 32'h0);
        check("async_rst_irq", {31'h0, uart_irq}, 32'h1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        bus(32'h8, 32'h0, 4'h0, r);
        check("divisor_after_rst", r, 32'd867);
        bus(32'h4, 32'h0, 4'h0, r);
        check("status_after_rst", r, 32'h0000_0002);
        t0 = cyc;
        repeat (300) @(negedge clock);
        lows = 0;
        for (int i = t0; i < cyc && i < LOGN; i++) if (txlog[i] !== 1'b1) lows++;
        check("no_frame_after_rst", lows, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
